// File: rtl/gtfraw_vnc_lat_hist_pkg.sv
// Shared types and helpers for the latency histogram stage.
package gtfraw_vnc_lat_hist_pkg;

   // Bin index width carried in the S1 pipeline record
   localparam int LH_BIN_ADDR_WIDTH = 6;

   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } state_t;

   // One binned event waiting for its S2 read-modify-write
   typedef struct packed {
      logic                         vld;
      logic                         udf;
      logic                         ovf;
      logic [LH_BIN_ADDR_WIDTH-1:0] idx;
   } s1_t;

   // Increment that sticks at max_val instead of wrapping
   function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                           input logic [63:0] max_val);
      return (val >= max_val) ? max_val : val + 64'd1;
   endfunction

endpackage

// File: rtl/gtfraw_vnc_lat_hist_bin.sv
// Adjust, underflow detect, bin index and overflow clamp for one delta event.
module gtfraw_vnc_lat_hist_bin #(
   parameter int TIMER_WIDTH    = 16,
   parameter int NUM_BINS       = 64,
   parameter int BIN_ADDR_WIDTH = 6,
   parameter int BIN_SHIFT      = 2
) (
   input  logic [TIMER_WIDTH-1:0]    delta_time,
   input  logic [TIMER_WIDTH-1:0]    delta_adj,
   output logic                      udf,
   output logic                      ovf,
   output logic [BIN_ADDR_WIDTH-1:0] idx
);

   logic [TIMER_WIDTH:0]   diff;
   logic [TIMER_WIDTH-1:0] idx_full;

   // Extra MSB of the difference is the borrow; anything past the last bin clamps
   always_comb begin
      diff     = {1'b0, delta_time} - {1'b0, delta_adj};
      idx_full = TIMER_WIDTH'(diff[TIMER_WIDTH-1:0] >> BIN_SHIFT);
      udf      = diff[TIMER_WIDTH];
      ovf      = 1'b0;
      idx      = '0;
      if (!udf) begin
         if (idx_full > TIMER_WIDTH'(NUM_BINS - 1)) begin
            ovf = 1'b1;
            idx = BIN_ADDR_WIDTH'(NUM_BINS - 1);
         end else begin
            idx = idx_full[BIN_ADDR_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/gtfraw_vnc_lat_hist.sv
// Latency histogram: bins adjusted delta-time events into a saturating
// counter array, with single-bin readback and a clear sweep after reset.
module gtfraw_vnc_lat_hist
   import gtfraw_vnc_lat_hist_pkg::*;
#(
   parameter int TIMER_WIDTH    = 16,
   parameter int NUM_BINS       = 64,
   parameter int BIN_ADDR_WIDTH = LH_BIN_ADDR_WIDTH,
   parameter int BIN_SHIFT      = 2,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      lat_clk,
   input  logic                      lat_rstn,
   input  logic                      hist_en,
   input  logic                      hist_clear,
   input  logic                      delta_valid,
   input  logic [TIMER_WIDTH-1:0]    delta_time,
   input  logic [TIMER_WIDTH-1:0]    delta_adj,
   input  logic                      rd_req,
   input  logic [BIN_ADDR_WIDTH-1:0] rd_addr,
   output logic                      rd_valid,
   output logic [CNT_WIDTH-1:0]      rd_data,
   output logic                      busy,
   output logic [CNT_WIDTH-1:0]      total_cnt,
   output logic [CNT_WIDTH-1:0]      ovf_cnt,
   output logic [CNT_WIDTH-1:0]      udf_cnt
);

   localparam logic [BIN_ADDR_WIDTH-1:0] LAST_BIN = BIN_ADDR_WIDTH'(NUM_BINS - 1);
   localparam logic [63:0]               CNT_MAX  = 64'({CNT_WIDTH{1'b1}});

   state_t                    state_reg;
   logic [BIN_ADDR_WIDTH-1:0] ptr_reg;
   logic                      busy_reg;
   s1_t                       s1_reg;
   s1_t                       s1_next;
   logic [CNT_WIDTH-1:0]      bin_mem [NUM_BINS];
   logic [CNT_WIDTH-1:0]      bin_next;
   logic                      s2_wr;
   logic                      accept;
   logic                      bin_udf;
   logic                      bin_ovf;
   logic [BIN_ADDR_WIDTH-1:0] bin_idx;
   logic                      rd_valid_reg;
   logic [CNT_WIDTH-1:0]      rd_data_reg;
   logic [CNT_WIDTH-1:0]      total_cnt_reg;
   logic [CNT_WIDTH-1:0]      ovf_cnt_reg;
   logic [CNT_WIDTH-1:0]      udf_cnt_reg;

   gtfraw_vnc_lat_hist_bin #(
      .TIMER_WIDTH    (TIMER_WIDTH),
      .NUM_BINS       (NUM_BINS),
      .BIN_ADDR_WIDTH (BIN_ADDR_WIDTH),
      .BIN_SHIFT      (BIN_SHIFT)
   ) u_bin (
      .delta_time (delta_time),
      .delta_adj  (delta_adj),
      .udf        (bin_udf),
      .ovf        (bin_ovf),
      .idx        (bin_idx)
   );

   // Clear has priority over a same-cycle event and also kills whatever sits in S1
   always_comb begin
      accept       = delta_valid & hist_en & (state_reg == RUN) & ~hist_clear;
      s1_next.vld  = accept;
      s1_next.udf  = bin_udf;
      s1_next.ovf  = bin_ovf;
      s1_next.idx  = bin_idx;
      s2_wr        = s1_reg.vld & ~s1_reg.udf & ~hist_clear;
      bin_next     = CNT_WIDTH'(sat_inc(64'(bin_mem[s1_reg.idx]), CNT_MAX));
   end

   // Sweep/run control: reset and hist_clear both restart the clearing sweep
   always_ff @(posedge lat_clk) begin
      if (!lat_rstn || hist_clear) begin
         state_reg <= SWEEP;
         ptr_reg   <= '0;
         busy_reg  <= 1'b1;
      end else begin
         case (state_reg)
            SWEEP: begin
               ptr_reg <= ptr_reg + 1'b1;
               if (ptr_reg == LAST_BIN) begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // S1: register the binned event
   always_ff @(posedge lat_clk) begin
      if (!lat_rstn || hist_clear) begin
         s1_reg <= '0;
      end else begin
         s1_reg <= s1_next;
      end
   end

   // Counter array: sweep writes zero, otherwise S2 read-modify-write of one bin
   always_ff @(posedge lat_clk) begin
      if (state_reg == SWEEP) begin
         bin_mem[ptr_reg] <= '0;
      end else if (s2_wr) begin
         bin_mem[s1_reg.idx] <= bin_next;
      end
   end

   // S2: scalar counters
   always_ff @(posedge lat_clk) begin
      if (!lat_rstn || hist_clear) begin
         total_cnt_reg <= '0;
         ovf_cnt_reg   <= '0;
         udf_cnt_reg   <= '0;
      end else if (s1_reg.vld) begin
         if (s1_reg.udf) begin
            udf_cnt_reg <= CNT_WIDTH'(sat_inc(64'(udf_cnt_reg), CNT_MAX));
         end else begin
            total_cnt_reg <= CNT_WIDTH'(sat_inc(64'(total_cnt_reg), CNT_MAX));
            if (s1_reg.ovf) begin
               ovf_cnt_reg <= CNT_WIDTH'(sat_inc(64'(ovf_cnt_reg), CNT_MAX));
            end
         end
      end
   end

   // Registered readback; sees the array as it was before this edge's S2 write
   always_ff @(posedge lat_clk) begin
      if (!lat_rstn) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         rd_valid_reg <= rd_req;
         if (rd_req) begin
            rd_data_reg <= bin_mem[rd_addr];
         end
      end
   end

   assign rd_valid  = rd_valid_reg;
   assign rd_data   = rd_data_reg;
   assign busy      = busy_reg;
   assign total_cnt = total_cnt_reg;
   assign ovf_cnt   = ovf_cnt_reg;
   assign udf_cnt   = udf_cnt_reg;

endmodule

// File: tb/tb_gtfraw_vnc_lat_hist.sv
// Directed bench for the latency histogram: binning table, then multi-cycle sequences.
module tb_gtfraw_vnc_lat_hist;

   logic        clk = 1'b0;
   logic        rstn;
   logic        hist_en;
   logic        hist_clear;
   logic        delta_valid;
   logic        delta_valid_s;
   logic [15:0] delta_time;
   logic [15:0] delta_adj;
   logic        rd_req;
   logic [5:0]  rd_addr;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        busy;
   logic [31:0] total_cnt;
   logic [31:0] ovf_cnt;
   logic [31:0] udf_cnt;
   logic        rd_valid_s;
   logic [3:0]  rd_data_s;
   logic        busy_s;
   logic [3:0]  total_cnt_s;
   logic [3:0]  ovf_cnt_s;
   logic [3:0]  udf_cnt_s;
   logic [15:0] tv_time;
   logic [15:0] tv_adj;
   logic        tv_udf;
   logic        tv_ovf;
   logic [5:0]  tv_idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gtfraw_vnc_lat_hist dut (
      .lat_clk     (clk),
      .lat_rstn    (rstn),
      .hist_en     (hist_en),
      .hist_clear  (hist_clear),
      .delta_valid (delta_valid),
      .delta_time  (delta_time),
      .delta_adj   (delta_adj),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .busy        (busy),
      .total_cnt   (total_cnt),
      .ovf_cnt     (ovf_cnt),
      .udf_cnt     (udf_cnt)
   );

   gtfraw_vnc_lat_hist #(.CNT_WIDTH(4)) dut_s (
      .lat_clk     (clk),
      .lat_rstn    (rstn),
      .hist_en     (hist_en),
      .hist_clear  (hist_clear),
      .delta_valid (delta_valid_s),
      .delta_time  (delta_time),
      .delta_adj   (delta_adj),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_valid    (rd_valid_s),
      .rd_data     (rd_data_s),
      .busy        (busy_s),
      .total_cnt   (total_cnt_s),
      .ovf_cnt     (ovf_cnt_s),
      .udf_cnt     (udf_cnt_s)
   );

   gtfraw_vnc_lat_hist_bin u_bin (
      .delta_time (tv_time),
      .delta_adj  (tv_adj),
      .udf        (tv_udf),
      .ovf        (tv_ovf),
      .idx        (tv_idx)
   );

   typedef struct {
      logic [15:0] dt;
      logic [15:0] da;
      logic        udf;
      logic        ovf;
      logic [5:0]  idx;
   } bin_vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] dt, input logic [15:0] da);
      delta_valid = 1'b1;
      delta_time  = dt;
      delta_adj   = da;
      tick();
      delta_valid = 1'b0;
   endtask

   task automatic rd_bin(input int a, output logic v, output logic [31:0] d, output logic [3:0] ds);
      rd_req  = 1'b1;
      rd_addr = 6'(a);
      tick();
      v      = rd_valid;
      d      = rd_data;
      ds     = rd_data_s;
      rd_req = 1'b0;
      $display("read bin %0d -> %0d (valid %0d)", a, d, v);
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic check_all_zero(input string name);
      logic        v;
      logic [31:0] d;
      logic [3:0]  ds;
      for (int i = 0; i < 64; i++) begin
         rd_bin(i, v, d, ds);
         check({name, "_valid"}, 64'(v), 64'd1);
         check(name, 64'(d), 64'd0);
      end
   endtask

   initial begin
      bin_vec_t    vecs [11];
      logic        v;
      logic [31:0] d;
      logic [3:0]  ds;
      int          n;

      vecs[0]  = '{16'd10,    16'd10, 1'b0, 1'b0, 6'd0};
      vecs[1]  = '{16'd13,    16'd10, 1'b0, 1'b0, 6'd0};
      vecs[2]  = '{16'd14,    16'd10, 1'b0, 1'b0, 6'd1};
      vecs[3]  = '{16'd265,   16'd10, 1'b0, 1'b0, 6'd63};
      vecs[4]  = '{16'd270,   16'd10, 1'b0, 1'b1, 6'd63};
      vecs[5]  = '{16'd5,     16'd20, 1'b1, 1'b0, 6'd0};
      vecs[6]  = '{16'd0,     16'd0,  1'b0, 1'b0, 6'd0};
      vecs[7]  = '{16'd65535, 16'd0,  1'b0, 1'b1, 6'd63};
      vecs[8]  = '{16'd259,   16'd0,  1'b0, 1'b1, 6'd63};
      vecs[9]  = '{16'd255,   16'd0,  1'b0, 1'b0, 6'd63};
      vecs[10] = '{16'd0,     16'd1,  1'b1, 1'b0, 6'd0};

      rstn = 1'b0; hist_en = 1'b0; hist_clear = 1'b0;
      delta_valid = 1'b0; delta_valid_s = 1'b0;
      delta_time = '0; delta_adj = '0; rd_req = 1'b0; rd_addr = '0;
      tv_time = '0; tv_adj = '0;
      repeat (3) tick();

      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_total", 64'(total_cnt), 64'd0);
      check("rst_ovf", 64'(ovf_cnt), 64'd0);
      check("rst_udf", 64'(udf_cnt), 64'd0);
      check("rst_busy", 64'(busy), 64'd1);

      // Binning unit table
      for (int i = 0; i < 11; i++) begin
         tv_time = vecs[i].dt;
         tv_adj  = vecs[i].da;
         #1;
         $display("bin vec %0d: dt=%0d adj=%0d -> udf=%0d ovf=%0d idx=%0d", i, tv_time, tv_adj, tv_udf, tv_ovf, tv_idx);
         check("bin_udf", 64'(tv_udf), 64'(vecs[i].udf));
         check("bin_ovf", 64'(tv_ovf), 64'(vecs[i].ovf));
         check("bin_idx", 64'(tv_idx), 64'(vecs[i].idx));
      end

      // Reset release: busy lasts exactly 64 cycles
      rstn = 1'b1;
      busy_len(n);
      check("reset_busy_cycles", 64'(n), 64'd64);
      check("sat_dut_busy", 64'(busy_s), 64'd0);
      check_all_zero("post_reset_bin");
      tick();
      check("rd_valid_pulse", 64'(rd_valid), 64'd0);

      // Basic binning
      hist_en = 1'b1;
      send(16'd10, 16'd10);
      send(16'd13, 16'd10);
      send(16'd14, 16'd10);
      send(16'd265, 16'd10);
      tick(); tick();
      rd_bin(0, v, d, ds);  check("bin0", 64'(d), 64'd2);
      rd_bin(1, v, d, ds);  check("bin1", 64'(d), 64'd1);
      rd_bin(63, v, d, ds); check("bin63", 64'(d), 64'd1);
      check("total_4", 64'(total_cnt), 64'd4);
      check("ovf_0", 64'(ovf_cnt), 64'd0);

      send(16'd270, 16'd10);
      tick(); tick();
      rd_bin(63, v, d, ds); check("bin63_ovf", 64'(d), 64'd2);
      check("ovf_1", 64'(ovf_cnt), 64'd1);
      check("total_5", 64'(total_cnt), 64'd5);

      // Underflow is counted but not binned
      send(16'd5, 16'd20);
      tick(); tick();
      check("udf_1", 64'(udf_cnt), 64'd1);
      check("total_after_udf", 64'(total_cnt), 64'd5);
      rd_bin(0, v, d, ds); check("bin0_after_udf", 64'(d), 64'd2);

      // Disabled: event dropped
      hist_en = 1'b0;
      send(16'd10, 16'd10);
      tick(); tick();
      check("total_hist_en_off", 64'(total_cnt), 64'd5);
      hist_en = 1'b1;

      // 100 back-to-back events into bin 10; read two cycles after the last
      delta_time = 16'd40; delta_adj = 16'd0; delta_valid = 1'b1;
      repeat (100) tick();
      delta_valid = 1'b0;
      tick();
      rd_bin(10, v, d, ds);
      check("burst_bin10", 64'(d), 64'd100);
      check("burst_total", 64'(total_cnt), 64'd105);

      // Saturation on the 4-bit instance
      delta_time = 16'd20; delta_adj = 16'd0; delta_valid_s = 1'b1;
      repeat (20) tick();
      delta_valid_s = 1'b0;
      tick(); tick();
      rd_bin(5, v, d, ds);
      check("sat_bin5", 64'(ds), 64'd15);
      check("sat_total", 64'(total_cnt_s), 64'd15);
      check("sat_ovf", 64'(ovf_cnt_s), 64'd0);

      // Clear with S1 occupied and a same-cycle event: both discarded
      send(16'd40, 16'd0);
      delta_valid = 1'b1; hist_clear = 1'b1;
      tick();
      delta_valid = 1'b0; hist_clear = 1'b0;
      check("clr_total", 64'(total_cnt), 64'd0);
      check("clr_ovf", 64'(ovf_cnt), 64'd0);
      check("clr_udf", 64'(udf_cnt), 64'd0);
      check("clr_busy", 64'(busy), 64'd1);
      check("clr_sat_total", 64'(total_cnt_s), 64'd0);
      busy_len(n);
      check("clear_busy_cycles", 64'(n), 64'd64);
      check_all_zero("post_clear_bin");
      check("clr_total_final", 64'(total_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
